cache_control: RTL and testbench
================================

# cache_control

Write-back, write-allocate controller for the 2-way set-associative L1 cache (8 sets, 256-bit lines). It sequences the per-way data, tag, valid and dirty arrays and the LRU array, and runs line writebacks and fills on the physical-memory port. It sits between the CPU memory interface and the cache datapath. Hit, dirty and LRU status arrive as combinational inputs from the datapath; all array load strobes and mux selects are outputs.

## Interface
- No parameters. Geometry is fixed by the datapath.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mem_read, mem_write  in  1 each  CPU request, held until mem_resp
- hit0, hit1  in  1 each  valid && tag match per way, combinational
- dirty0, dirty1  in  1 each  dirty bit of the indexed set per way
- lru_out  in  1  way to evict for the indexed set
- pmem_resp  in  1  physical memory done, single-cycle pulse
- mem_resp  out  1  CPU request complete
- pmem_read, pmem_write  out  1 each  physical memory request
- pmem_addr_sel  out  1  0 = CPU address, 1 = {victim tag, index, 5'b0}
- data_in_sel  out  1  0 = CPU write-merged line, 1 = pmem line
- way_sel  out  1  way driven to the data-out mux and writeback path
- load_data, load_tag, load_valid, load_dirty  out  2 each  per-way array write enables
- dirty_in  out  1  value written to the dirty array
- load_lru, lru_in  out  1 each  LRU array write enable and data

## Operation
- States: IDLE, WRITEBACK, ALLOCATE.
- Defaults in every state: all outputs 0.
- IDLE, no request: stay in IDLE.
- IDLE, hit (hit0|hit1) on read:
  - mem_resp=1.
  - way_sel = hit way.
  - load_lru=1, lru_in = ~hit way.
- IDLE, hit on write:
  - All of the read-hit outputs.
  - data_in_sel=0.
  - load_data[hw]=1, load_dirty[hw]=1, dirty_in=1.
- IDLE, miss: victim v = lru_out.
  - If dirty_v, go to WRITEBACK.
  - Otherwise go to ALLOCATE.
  - mem_resp stays 0.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, way_sel=v.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0, data_in_sel=1, way_sel=v.
  - On pmem_resp: load_data[v], load_tag[v], load_valid[v] and load_dirty[v] = 1, dirty_in=0.
  - Then go to IDLE. The request now hits and completes there.
- v is registered on the IDLE→miss transition and held through WRITEBACK and ALLOCATE. lru_out is never re-sampled mid-miss.
- Both hit0 and hit1 set (illegal): way 0 wins.

## Timing
- Reset: state=IDLE, registered victim=0. All outputs 0 in the cycle after rst is sampled.
- Reset mid-miss: pmem_read/pmem_write drop the next cycle and no array load fires.
- Hit latency: mem_resp in the same cycle the request is presented in IDLE (combinational from inputs).
- Clean miss:
  - 1 cycle IDLE, then ALLOCATE until pmem_resp, then 1 cycle IDLE.
  - mem_resp at pmem_resp cycle + 1.
- Dirty miss: WRITEBACK adds a wait for the first pmem_resp. pmem_read asserts the cycle after that pmem_resp.
- pmem_read and pmem_write are never asserted together.
- pmem_read and pmem_write stay high continuously until pmem_resp.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- The CPU must hold its request and address until mem_resp. Dropping the request mid-miss still completes the fill, then IDLE responds to nothing.

## Structure
- Package cache_types:
  - state enum {IDLE, WRITEBACK, ALLOCATE}
  - pmem_addr_sel enum {ADDR_CPU, ADDR_VICTIM}
  - data_in_sel enum {DIN_CPU, DIN_PMEM}
- Single module: state register, victim register, one combinational output/next-state block. No sub-module.

## Test plan
- Reset:
  - Hold rst 2 cycles with mem_read=1 and hit0=1.
  - Required: mem_resp=0 during reset; IDLE afterward; mem_resp=1 on the first post-reset cycle.
- Read hit way 1:
  - mem_read=1, hit1=1.
  - Required: same-cycle mem_resp=1, way_sel=1, load_lru=1, lru_in=0; no load_data.
- Write hit way 0:
  - mem_write=1, hit0=1.
  - Required: load_data=2'b01, load_dirty=2'b01, dirty_in=1, data_in_sel=0, mem_resp=1.
- Clean miss:
  - mem_read=1, no hit, lru_out=1, dirty1=0. pmem_resp after 3 ALLOCATE cycles.
  - Required: pmem_read high 3 cycles; at resp, load_data/tag/valid/dirty=2'b10 with dirty_in=0; mem_resp 1 cycle later once hit1=1.
- Dirty miss:
  - lru_out=0, dirty0=1. Toggle lru_out to 1 mid-WRITEBACK.
  - Required: pmem_write with pmem_addr_sel=1 and way_sel=0, then pmem_read; fill loads way 0 (2'b01); pmem_read/write never overlap.
- Reset in ALLOCATE:
  - Assert rst while pmem_read=1.
  - Required: pmem_read=0 and all loads=0 next cycle; a later stray pmem_resp is ignored.

Source files
------------

// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller: FSM states and datapath mux encodings.
package cache_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    typedef enum logic {
        ADDR_CPU    = 1'b0,
        ADDR_VICTIM = 1'b1
    } pmem_addr_sel_t;

    typedef enum logic {
        DIN_CPU  = 1'b0,
        DIN_PMEM = 1'b1
    } data_in_sel_t;

    // One-hot per-way write-enable mask for a 2-way array.
    function automatic logic [1:0] way_mask(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_control.sv
// Write-back, write-allocate controller for the 2-way set-associative L1 (8 sets, 256-bit lines).
// Latency: hits respond in the request cycle; misses add a writeback (if dirty) and a fill, then respond one cycle after the fill.
// Backpressure: the CPU holds its request until mem_resp; pmem requests stay high until pmem_resp.
module cache_control
    import cache_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       hit0,
    input  logic       hit1,
    input  logic       dirty0,
    input  logic       dirty1,
    input  logic       lru_out,
    input  logic       pmem_resp,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    output logic       pmem_addr_sel,
    output logic       data_in_sel,
    output logic       way_sel,
    output logic [1:0] load_data,
    output logic [1:0] load_tag,
    output logic [1:0] load_valid,
    output logic [1:0] load_dirty,
    output logic       dirty_in,
    output logic       load_lru,
    output logic       lru_in
);

    state_t state, next_state;
    logic   victim, next_victim;
    logic   hit, hit_way, victim_dirty, request;

    assign request      = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    // Way 0 wins if both ways claim a hit.
    assign hit_way      = hit0 ? 1'b0 : 1'b1;
    assign victim_dirty = lru_out ? dirty1 : dirty0;

    always_comb begin
        next_state    = state;
        next_victim   = victim;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = ADDR_CPU;
        data_in_sel   = DIN_CPU;
        way_sel       = 1'b0;
        load_data     = 2'b00;
        load_tag      = 2'b00;
        load_valid    = 2'b00;
        load_dirty    = 2'b00;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;

        // Outputs are held quiet while reset is asserted so no array or pmem strobe escapes.
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (request && hit) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        if (mem_write) begin
                            data_in_sel = DIN_CPU;
                            load_data   = way_mask(hit_way);
                            load_dirty  = way_mask(hit_way);
                            dirty_in    = 1'b1;
                        end
                    end else if (request) begin
                        next_victim = lru_out;
                        next_state  = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = ADDR_VICTIM;
                    way_sel       = victim;
                    if (pmem_resp)
                        next_state = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read     = 1'b1;
                    pmem_addr_sel = ADDR_CPU;
                    data_in_sel   = DIN_PMEM;
                    way_sel       = victim;
                    if (pmem_resp) begin
                        load_data  = way_mask(victim);
                        load_tag   = way_mask(victim);
                        load_valid = way_mask(victim);
                        load_dirty = way_mask(victim);
                        dirty_in   = 1'b0;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            state  <= next_state;
            victim <= next_victim;
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control: hits, clean/dirty misses, and reset mid-fill.
module tb_cache_control;
    import cache_types::*;

    logic       clk = 1'b0;
    logic       rst, mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru_out, pmem_resp;
    logic       mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, way_sel;
    logic [1:0] load_data, load_tag, load_valid, load_dirty;
    logic       dirty_in, load_lru, lru_in;

    int n_checks = 0;
    int n_fails  = 0;
    int rd_cycles;

    always #5 clk = ~clk;

    cache_control dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
        .lru_out(lru_out), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
        .data_in_sel(data_in_sel), .way_sel(way_sel), .load_data(load_data),
        .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty),
        .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow after #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_loads_zero(input string tag);
        check({tag, ".load_data"},  32'(load_data),  32'd0);
        check({tag, ".load_tag"},   32'(load_tag),   32'd0);
        check({tag, ".load_valid"}, 32'(load_valid), 32'd0);
        check({tag, ".load_dirty"}, 32'(load_dirty), 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit0 = 1'b1; hit1 = 1'b0;
        dirty0 = 1'b0; dirty1 = 1'b0; lru_out = 1'b0; pmem_resp = 1'b0;

        // Reset held two cycles with a hitting read pending.
        #2;
        check("rst_c0.mem_resp", 32'(mem_resp), 32'd0);
        tick();
        check("rst_c1.mem_resp", 32'(mem_resp), 32'd0);
        check("rst_c1.load_lru", 32'(load_lru), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst.state", 32'(dut.state), 32'(IDLE));
        check("post_rst.mem_resp", 32'(mem_resp), 32'd1);
        check("post_rst.pmem_read", 32'(pmem_read), 32'd0);

        // Read hit on way 1.
        hit0 = 1'b0; hit1 = 1'b1;
        #1;
        check("rdhit1.mem_resp", 32'(mem_resp), 32'd1);
        check("rdhit1.way_sel", 32'(way_sel), 32'd1);
        check("rdhit1.load_lru", 32'(load_lru), 32'd1);
        check("rdhit1.lru_in", 32'(lru_in), 32'd0);
        check("rdhit1.load_data", 32'(load_data), 32'd0);

        // Write hit on way 0.
        mem_read = 1'b0; mem_write = 1'b1; hit0 = 1'b1; hit1 = 1'b0;
        #1;
        check("wrhit0.load_data", 32'(load_data), 32'b01);
        check("wrhit0.load_dirty", 32'(load_dirty), 32'b01);
        check("wrhit0.dirty_in", 32'(dirty_in), 32'd1);
        check("wrhit0.data_in_sel", 32'(data_in_sel), 32'd0);
        check("wrhit0.mem_resp", 32'(mem_resp), 32'd1);
        check("wrhit0.lru_in", 32'(lru_in), 32'd1);

        // Both hits set: way 0 wins.
        hit1 = 1'b1;
        #1;
        check("bothhit.way_sel", 32'(way_sel), 32'd0);
        check("bothhit.load_data", 32'(load_data), 32'b01);

        // Clean miss: victim way 1 (way 0 dirty, must not matter).
        tick();
        mem_write = 1'b0; mem_read = 1'b1; hit0 = 1'b0; hit1 = 1'b0;
        lru_out = 1'b1; dirty1 = 1'b0; dirty0 = 1'b1;
        #1;
        check("clean_idle.mem_resp", 32'(mem_resp), 32'd0);
        check("clean_idle.pmem_req", 32'({pmem_read, pmem_write}), 32'd0);
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lru_out   = 1'b0;
            pmem_resp = (i == 2);
            #1;
            if (pmem_read) rd_cycles++;
            check("clean_alloc.pmem_write", 32'(pmem_write), 32'd0);
            check("clean_alloc.way_sel", 32'(way_sel), 32'd1);
            check("clean_alloc.data_in_sel", 32'(data_in_sel), 32'd1);
            check("clean_alloc.addr_sel", 32'(pmem_addr_sel), 32'd0);
            if (i < 2) check("clean_alloc.load_data_early", 32'(load_data), 32'd0);
        end
        check("clean.pmem_read_cycles", 32'(rd_cycles), 32'd3);
        check("clean_resp.load_data", 32'(load_data), 32'b10);
        check("clean_resp.load_tag", 32'(load_tag), 32'b10);
        check("clean_resp.load_valid", 32'(load_valid), 32'b10);
        check("clean_resp.load_dirty", 32'(load_dirty), 32'b10);
        check("clean_resp.dirty_in", 32'(dirty_in), 32'd0);
        check("clean_resp.mem_resp", 32'(mem_resp), 32'd0);
        tick();
        pmem_resp = 1'b0; hit1 = 1'b1;
        #1;
        check("clean_done.mem_resp", 32'(mem_resp), 32'd1);
        check("clean_done.pmem_read", 32'(pmem_read), 32'd0);
        check("clean_done.way_sel", 32'(way_sel), 32'd1);

        // Dirty miss: victim way 0; lru_out flips mid-writeback and must be ignored.
        tick();
        hit1 = 1'b0; lru_out = 1'b0; dirty0 = 1'b1; dirty1 = 1'b0;
        #1;
        check("dirty_idle.pmem_write", 32'(pmem_write), 32'd0);
        tick();
        #1;
        check("wb.pmem_write", 32'(pmem_write), 32'd1);
        check("wb.pmem_read", 32'(pmem_read), 32'd0);
        check("wb.addr_sel", 32'(pmem_addr_sel), 32'd1);
        check("wb.way_sel", 32'(way_sel), 32'd0);
        tick();
        lru_out = 1'b1;
        #1;
        check("wb_toggle.way_sel", 32'(way_sel), 32'd0);
        check("wb_toggle.pmem_write", 32'(pmem_write), 32'd1);
        tick();
        pmem_resp = 1'b1;
        #1;
        check("wb_resp.pmem_write", 32'(pmem_write), 32'd1);
        check_loads_zero("wb_resp");
        tick();
        pmem_resp = 1'b0;
        #1;
        check("dalloc.pmem_read", 32'(pmem_read), 32'd1);
        check("dalloc.pmem_write", 32'(pmem_write), 32'd0);
        check("dalloc.way_sel", 32'(way_sel), 32'd0);
        check("dalloc.addr_sel", 32'(pmem_addr_sel), 32'd0);
        tick();
        pmem_resp = 1'b1;
        #1;
        check("dalloc_resp.load_data", 32'(load_data), 32'b01);
        check("dalloc_resp.load_tag", 32'(load_tag), 32'b01);
        check("dalloc_resp.load_valid", 32'(load_valid), 32'b01);
        check("dalloc_resp.load_dirty", 32'(load_dirty), 32'b01);
        check("dalloc_resp.dirty_in", 32'(dirty_in), 32'd0);
        tick();
        pmem_resp = 1'b0; hit0 = 1'b1;
        #1;
        check("dirty_done.mem_resp", 32'(mem_resp), 32'd1);
        check("dirty_done.pmem_req", 32'({pmem_read, pmem_write}), 32'd0);

        // Reset while in ALLOCATE, then a stray pmem_resp.
        tick();
        hit0 = 1'b0; lru_out = 1'b0; dirty0 = 1'b0;
        #1;
        tick();
        #1;
        check("rstalloc.pmem_read_before", 32'(pmem_read), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_read = 1'b0;
        #1;
        check("rstalloc.pmem_read_after", 32'(pmem_read), 32'd0);
        check("rstalloc.pmem_write_after", 32'(pmem_write), 32'd0);
        check_loads_zero("rstalloc");
        tick();
        pmem_resp = 1'b1;
        #1;
        check("stray.pmem_read", 32'(pmem_read), 32'd0);
        check("stray.mem_resp", 32'(mem_resp), 32'd0);
        check_loads_zero("stray");
        tick();
        pmem_resp = 1'b0;
        #1;
        check("stray_after.state", 32'(dut.state), 32'(IDLE));
        check("stray_after.pmem_req", 32'({pmem_read, pmem_write}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Read and write requests to physical memory must never overlap.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            assert (!(pmem_read && pmem_write)) else begin
                n_fails++;
                $error("FAIL pmem_overlap: observed read=%0b write=%0b expected not both", pmem_read, pmem_write);
            end
        end
    end

endmodule
